fpadd_scheduler: RTL and testbench
==================================

# fpadd_scheduler

Shares one serial-operand `fpadder` among `N` requesters. Each requester hands over an operand pair with a valid/ready handshake. The scheduler picks one requester round-robin and drives operand m, then operand n, onto the adder's 32-bit `a` bus on consecutive cycles. It waits for the adder's `ready`, then returns the sum tagged with the requester id, with a timeout guard. It sits between the FP client blocks and the single `fpadder` instance.

## Interface
Parameters:
- `N`, 4: number of requesters, 2–8.
- `TIMEOUT`, 64: maximum WAIT cycles before the operation is aborted; at least 4.

Ports:
- `clock`  in  1  single clock; everything is rising-edge.
- `nreset`  in  1  reset; synchronous, active-low.
- `req_valid`  in  N  requester i has an operand pair pending.
- `req_a`  in  N*32  operand m of requester i, in bits [32i+31:32i].
- `req_b`  in  N*32  operand n of requester i, same slicing.
- `req_ready`  out  N  one-hot, one-cycle pulse: pair from requester i accepted this cycle.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  $clog2(N)  requester index of the result.
- `resp_sum`  out  32  IEEE-754 single result.
- `resp_err`  out  1  result was produced by timeout, not by the adder.
- `add_a`  out  32  drives `fpadder.a`.
- `add_ready`  in  1  `fpadder.ready`.
- `add_sum`  in  32  `fpadder.sum`.

## Operation
- FSM states: IDLE, LOAD_M, LOAD_N, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, grant the first valid index at or after `rr_ptr`, wrapping modulo N.
  - Pulse `req_ready[g]`, latch `req_a[g]`, `req_b[g]` and g, then go to LOAD_M.
  - If no request is valid, stay in IDLE.
- LOAD_M: `add_a` = latched m for exactly one cycle, then go to LOAD_N.
- LOAD_N: `add_a` = latched n for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - `add_a` = 0.
  - `add_ready` is sampled only in this state.
  - On the first cycle it is high, capture `add_sum` into `resp_sum`, set `resp_err`=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT−1 without `add_ready`, set `resp_sum`=0x7FC00000 (quiet NaN), set `resp_err`=1, go to RESP.
- RESP:
  - `resp_valid`=1; `resp_id`, `resp_sum` and `resp_err` are held stable.
  - On a cycle where `resp_ready` is high, go to IDLE and set `rr_ptr` = (g+1) mod N.
- `add_a` is 0 in IDLE, WAIT and RESP.
- Only one operation is in flight. No new grant is made until the response has been consumed.
- The requester must hold `req_a`/`req_b` stable while `req_valid` is high and until `req_ready` pulses. Dropping `req_valid` before the grant is legal.
- The scheduler performs no arithmetic. All IEEE special cases (±0, ±inf, NaN) come from the adder and are passed through unmodified.

## Timing
- Reset (`nreset` low at a rising edge):
  - state ← IDLE, `rr_ptr` ← 0, counter ← 0.
  - `req_ready`, `resp_valid`, `resp_err`, `resp_id` ← 0; `resp_sum` ← 0; `add_a` ← 0.
- Reset mid-operation drops the in-flight pair with no response. The adder must be reset by the same `nreset`.
- Grant-to-operand latency:
  - `req_ready` pulses in cycle T.
  - m is on `add_a` in T+1, n in T+2.
  - WAIT starts at T+3.
- Result latency: if `add_ready` is first high in cycle W, `resp_valid` rises at W+1.
- Best-case turnaround is grant T, adder ready T+3, response T+4. If `resp_ready` is already high, IDLE is reached at T+5 and the next grant can occur in the IDLE cycle T+5.
- Timeout: with `add_ready` stuck low, `resp_valid` rises exactly TIMEOUT cycles after WAIT is entered.
- Simultaneous requests: exactly one `req_ready` bit is high, chosen by round-robin order from `rr_ptr`.
- A requester that re-asserts valid immediately after its grant cannot be granted again while another requester is valid.

## Structure
- Package `fpadd_sched_pkg`:
  - `sched_state_t` enum.
  - `FP_QNAN` = 32'h7FC00000, `FP_ZERO` = 32'h0.
  - Helper for the id width.
- Sub-module `rr_arbiter`: combinational rotate-priority grant from `req_valid` and `rr_ptr`, output one-hot plus index. Pointer update stays in `fpadd_scheduler`.
- `fpadder` is instantiated outside this block. The bench connects it directly to the `add_*` ports.

## Test plan
- Requester 0 sends m=0x3F800000, n=0x3F800000 with the real `fpadder` → `resp_sum`=0x40000000, `resp_id`=0, `resp_err`=0; `add_a` shows m then n on consecutive cycles.
- All 4 requesters valid at once (0x42280000 + 0x40490FD0 on each) → grants in order 0,1,2,3. Requester 0 re-asserts afterwards and is granted 5th, so the pointer wraps. Each result is 0x423490FD.
- `resp_ready` held low for 10 cycles → `resp_valid` and data stay stable, no `req_ready` pulses, and no further m/n operands appear on `add_a`. On release, the next grant occurs in the IDLE cycle immediately after.
- Stub adder with `add_ready` tied 0, TIMEOUT=64 → `resp_valid` 64 cycles after WAIT entry, `resp_sum`=0x7FC00000, `resp_err`=1.
- `nreset` low for one cycle during WAIT → all outputs 0 next cycle, no response for the dropped pair, `rr_ptr`=0. A pending requester 2 is then granted normally.
- Special-value pass-through with the real adder: m=0x7F800000 plus n=0xFF800000, and m=0x7F800000 plus n=0xFFC00000 → `resp_sum` equals the adder's `sum` exactly, `resp_err`=0.

Source files
------------

// File: rtl/fpadd_sched_pkg.sv
// Shared types and constants for the fpadder request scheduler.
package fpadd_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_M,
      S_LOAD_N,
      S_WAIT,
      S_RESP
   } sched_state_t;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fpadd_scheduler_rr_arbiter.sv
// Rotate-priority arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx,
   output logic           any
);

   always_comb begin
      int c;
      c   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr) + k) % N;
         if (!any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = IDW'(c);
         end
      end
   end

endmodule

// File: rtl/fpadd_scheduler.sv
// Shares one serial-operand fpadder among N requesters: round-robin grant,
// m then n on add_a, bounded wait for the adder, tagged response.
module fpadd_scheduler
   import fpadd_sched_pkg::*;
#(
   parameter int N       = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clock,
   input  logic                 nreset,
   input  logic [N-1:0]         req_valid,
   input  logic [N*32-1:0]      req_a,
   input  logic [N*32-1:0]      req_b,
   output logic [N-1:0]         req_ready,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [$clog2(N)-1:0] resp_id,
   output logic [31:0]          resp_sum,
   output logic                 resp_err,
   output logic [31:0]          add_a,
   input  logic                 add_ready,
   input  logic [31:0]          add_sum
);

   localparam int IDW = id_w(N);
   localparam int CW  = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   sched_state_t   state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] gid_q, gid_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    n_q, n_d;
   logic [31:0]    add_a_q, add_a_d;
   logic [31:0]    resp_sum_q, resp_sum_d;
   logic           resp_err_q, resp_err_d;

   logic [N-1:0]   arb_gnt;
   logic [IDW-1:0] arb_idx;
   logic           arb_any;

   rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gid_d      = gid_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      resp_sum_d = resp_sum_q;
      resp_err_d = resp_err_q;
      add_a_d    = FP_ZERO;
      req_ready  = '0;
      unique case (state_q)
         S_IDLE: begin
            // m goes straight into the add_a register so it appears in LOAD_M
            if (arb_any) begin
               req_ready = arb_gnt;
               gid_d     = arb_idx;
               add_a_d   = req_a[32*int'(arb_idx) +: 32];
               n_d       = req_b[32*int'(arb_idx) +: 32];
               state_d   = S_LOAD_M;
            end
         end
         S_LOAD_M: begin
            add_a_d = n_q;
            state_d = S_LOAD_N;
         end
         S_LOAD_N: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (add_ready) begin
               resp_sum_d = add_sum;
               resp_err_d = 1'b0;
               state_d    = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               resp_sum_d = FP_QNAN;
               resp_err_d = 1'b1;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d  = S_IDLE;
               rr_ptr_d = (gid_q == IDW'(N - 1)) ? '0 : gid_q + IDW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         gid_q      <= '0;
         cnt_q      <= '0;
         add_a_q    <= FP_ZERO;
         resp_sum_q <= FP_ZERO;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gid_q      <= gid_d;
         cnt_q      <= cnt_d;
         add_a_q    <= add_a_d;
         resp_sum_q <= resp_sum_d;
         resp_err_q <= resp_err_d;
      end
   end

   always_ff @(posedge clock) begin
      n_q <= n_d;
   end

   assign resp_valid = (state_q == S_RESP);
   assign resp_id    = gid_q;
   assign resp_sum   = resp_sum_q;
   assign resp_err   = resp_err_q;
   assign add_a      = add_a_q;

endmodule

// File: tb/tb_fpadd_scheduler.sv
// Scoreboard bench for fpadd_scheduler with a behavioural serial adder stub.
`timescale 1ns/1ps
module tb_fpadd_scheduler;

   localparam int N       = 4;
   localparam int TIMEOUT = 64;
   localparam int IDW     = $clog2(N);

   logic            clock = 1'b0;
   logic            nreset;
   logic [N-1:0]    req_valid;
   logic [N*32-1:0] req_a, req_b;
   logic [N-1:0]    req_ready;
   logic            resp_valid, resp_ready;
   logic [IDW-1:0]  resp_id;
   logic [31:0]     resp_sum;
   logic            resp_err;
   logic [31:0]     add_a;
   logic            add_ready;
   logic [31:0]     add_sum;

   fpadd_scheduler #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clock      (clock),
      .nreset     (nreset),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_err   (resp_err),
      .add_a      (add_a),
      .add_ready  (add_ready),
      .add_sum    (add_sum)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Adder behaviour: a few IEEE cases by table, otherwise an order-sensitive mix.
   function automatic logic [31:0] model_sum(input logic [31:0] m, input logic [31:0] n);
      if (m == 32'h3F800000 && n == 32'h3F800000) return 32'h40000000;
      if (m == 32'h42280000 && n == 32'h40490FD0) return 32'h423490FD;
      if (m == 32'h7F800000 && n == 32'hFF800000) return 32'h7FC00000;
      if (m == 32'h7F800000 && n == 32'hFFC00000) return 32'hFFC00000;
      return {n[15:0], m[31:16]} ^ (m + n);
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // Serial adder stub: operand m one cycle after the grant, n the next.
   int          cur_lat    = 1;
   logic        stub_stuck = 1'b0;
   int          ph = 0, wc = 0, s_lat = 1;
   logic        s_stuck = 1'b0;
   logic [31:0] cap_m = '0, cap_n = '0;

   always @(negedge clock) begin
      if (!nreset) begin
         ph = 0; wc = 0; add_ready = 1'b0; add_sum = '0;
      end else begin
         add_ready = 1'b0;
         if (req_ready != '0) begin
            chk("add_a_at_grant", add_a, 32'd0);
            ph = 1; s_lat = cur_lat; s_stuck = stub_stuck;
         end else begin
            case (ph)
               1: begin cap_m = add_a; ph = 2; end
               2: begin cap_n = add_a; ph = 3; wc = 0; end
               default: begin
                  chk("add_a_zero", add_a, 32'd0);
                  if (ph == 3) begin
                     wc++;
                     if (!s_stuck && wc == s_lat) begin
                        add_ready = 1'b1;
                        add_sum   = model_sum(cap_m, cap_n);
                        ph        = 0;
                     end
                  end
               end
            endcase
         end
      end
   end

   // Scoreboard: grants are predicted by round-robin search, responses popped and compared.
   typedef struct {
      int          id;
      logic [31:0] sum;
      logic        err;
      int          due;
   } exp_t;

   exp_t           sb[$];
   exp_t           cur;
   int             glog[$];
   int             exp_ptr = 0;
   bit             busy = 0, prev_rv = 0;
   int             n_consumed = 0;
   logic [31:0]    hold_sum, last_sum;
   logic [IDW-1:0] hold_id, last_id;
   logic           hold_err, last_err;

   always @(negedge clock) begin
      if (!nreset) begin
         sb.delete(); exp_ptr = 0; busy = 0; prev_rv = 0;
      end else begin
         if (req_ready != '0) begin
            int g;
            g = rr_pick(req_valid, exp_ptr);
            chk("grant_while_busy", 32'(busy), 32'd0);
            if (g < 0) chk("grant_without_request", 32'(req_ready), 32'd0);
            else begin
               chk("grant_onehot", 32'(req_ready), 32'(1) << g);
               sb.push_back('{id: g,
                              sum: stub_stuck ? 32'h7FC00000
                                              : model_sum(req_a[32*g +: 32], req_b[32*g +: 32]),
                              err: stub_stuck,
                              due: cyc + 3 + (stub_stuck ? TIMEOUT : cur_lat)});
               glog.push_back(g);
               busy = 1;
            end
         end else if (!busy && req_valid != '0) begin
            chk("grant_missing", 32'(req_ready), 32'(1) << rr_pick(req_valid, exp_ptr));
         end

         if (resp_valid === 1'b1) begin
            if (!prev_rv) begin
               if (sb.size() == 0) begin
                  chk("resp_unexpected", 32'(resp_valid), 32'd0);
                  cur.id = int'(resp_id);
               end else begin
                  cur = sb.pop_front();
                  chk("resp_id", 32'(resp_id), 32'(cur.id));
                  chk("resp_sum", resp_sum, cur.sum);
                  chk("resp_err", 32'(resp_err), 32'(cur.err));
                  chk("resp_latency", 32'(cyc), 32'(cur.due));
               end
               hold_sum = resp_sum; hold_id = resp_id; hold_err = resp_err;
               last_sum = resp_sum; last_id = resp_id; last_err = resp_err;
            end else begin
               chk("hold_sum", resp_sum, hold_sum);
               chk("hold_id", 32'(resp_id), 32'(hold_id));
               chk("hold_err", 32'(resp_err), 32'(hold_err));
            end
            if (resp_ready) begin
               busy = 0;
               exp_ptr = (cur.id + 1) % N;
               n_consumed++;
            end
            prev_rv = !resp_ready;
         end else begin
            prev_rv = 0;
         end
      end
   end

   // Requester agent: a granted pair is withdrawn; random traffic when enabled.
   bit rand_mode = 0;
   int rand_left = 0;

   task automatic step();
      logic [N-1:0] gr;
      @(negedge clock);
      gr = req_ready;
      @(posedge clock);
      #1;
      req_valid = req_valid & ~gr;
      if (rand_mode) begin
         resp_ready = ($urandom_range(0, 3) != 0);
         cur_lat    = $urandom_range(1, 6);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && rand_left > 0 && $urandom_range(0, 2) == 0) begin
               req_valid[i]       = 1'b1;
               req_a[32*i +: 32]  = $urandom;
               req_b[32*i +: 32]  = $urandom;
               rand_left--;
            end
         end
      end
   endtask

   task automatic wait_consumed(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (n_consumed < target && k < budget) begin step(); k++; end
      chk(name, 32'(n_consumed >= target), 32'd1);
   endtask

   task automatic wait_grants(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (glog.size() < target && k < budget) begin step(); k++; end
      chk(name, 32'(glog.size() >= target), 32'd1);
   endtask

   task automatic put(input int i, input logic [31:0] m, input logic [31:0] n);
      req_valid[i]      = 1'b1;
      req_a[32*i +: 32] = m;
      req_b[32*i +: 32] = n;
   endtask

   initial begin
      int base, start, k;
      int order_a[5];
      order_a = '{0, 1, 2, 3, 0};
      nreset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
      step(); step();
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_resp_sum", resp_sum, 32'd0);
      chk("rst_add_a", add_a, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      nreset = 1'b1;
      step();

      // single requester, best-case adder
      start = n_consumed;
      cur_lat = 1;
      put(0, 32'h3F800000, 32'h3F800000);
      wait_consumed(start + 1, 100, "t1_done");
      chk("t1_sum", last_sum, 32'h40000000);
      chk("t1_id", 32'(last_id), 32'd0);
      chk("t1_err", 32'(last_err), 32'd0);
      chk("t1_add_m", cap_m, 32'h3F800000);
      chk("t1_add_n", cap_n, 32'h3F800000);

      // moves the pointer back to 0 before the simultaneous-request test
      start = n_consumed;
      cur_lat = 3;
      put(3, 32'h12345678, 32'h9ABCDEF0);
      wait_consumed(start + 1, 100, "warm_done");
      chk("warm_id", 32'(last_id), 32'd3);

      // all four at once, requester 0 re-asserts after its grant
      start = n_consumed;
      base  = glog.size();
      cur_lat = 2;
      for (int i = 0; i < N; i++) put(i, 32'h42280000, 32'h40490FD0);
      wait_grants(base + 1, 50, "t2_first_grant");
      put(0, 32'h42280000, 32'h40490FD0);
      wait_consumed(start + 5, 300, "t2_done");
      chk("t2_grant_count", 32'(glog.size() - base), 32'd5);
      if (glog.size() >= base + 5)
         for (int i = 0; i < 5; i++) chk("t2_order", 32'(glog[base + i]), 32'(order_a[i]));
      chk("t2_sum", last_sum, 32'h423490FD);

      // consumer stall with another requester waiting
      start = n_consumed;
      resp_ready = 1'b0;
      put(1, 32'h01020304, 32'h0A0B0C0D);
      put(3, 32'h55AA55AA, 32'h33CC33CC);
      k = 0;
      while (resp_valid !== 1'b1 && k < 100) begin step(); k++; end
      chk("stall_resp_seen", 32'(resp_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_no_grant", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      step();
      chk("stall_release_grant", 32'(req_ready), 32'b1000);
      wait_consumed(start + 2, 100, "stall_done");

      // adder never answers
      start = n_consumed;
      stub_stuck = 1'b1;
      put(2, 32'h40400000, 32'h40800000);
      wait_consumed(start + 1, 200, "to_done");
      chk("to_sum", last_sum, 32'h7FC00000);
      chk("to_err", 32'(last_err), 32'd1);
      chk("to_id", 32'(last_id), 32'd2);

      // reset while waiting on the adder
      start = n_consumed;
      base  = glog.size();
      put(1, 32'h11111111, 32'h22222222);
      wait_grants(base + 1, 50, "rst_mid_grant");
      repeat (5) step();
      put(2, 32'h3F000000, 32'h3E800000);
      put(3, 32'h40000000, 32'h40000000);
      nreset = 1'b0;
      step();
      chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
      chk("rstmid_resp_err", 32'(resp_err), 32'd0);
      chk("rstmid_resp_id", 32'(resp_id), 32'd0);
      chk("rstmid_resp_sum", resp_sum, 32'd0);
      chk("rstmid_add_a", add_a, 32'd0);
      stub_stuck = 1'b0;
      cur_lat = 1;
      nreset = 1'b1;
      wait_consumed(start + 2, 100, "rstmid_done");
      chk("rstmid_grant_count", 32'(glog.size() - base), 32'd3);
      if (glog.size() >= base + 3) begin
         chk("rstmid_first", 32'(glog[base + 1]), 32'd2);
         chk("rstmid_second", 32'(glog[base + 2]), 32'd3);
      end

      // special values pass through unmodified
      start = n_consumed;
      cur_lat = 4;
      put(0, 32'h7F800000, 32'hFF800000);
      wait_consumed(start + 1, 100, "sp1_done");
      chk("sp1_sum", last_sum, 32'h7FC00000);
      chk("sp1_err", 32'(last_err), 32'd0);
      put(1, 32'h7F800000, 32'hFFC00000);
      wait_consumed(start + 2, 100, "sp2_done");
      chk("sp2_sum", last_sum, 32'hFFC00000);
      chk("sp2_err", 32'(last_err), 32'd0);

      // random traffic
      start = n_consumed;
      rand_left = 40;
      rand_mode = 1;
      wait_consumed(start + 40, 5000, "rand_done");
      rand_mode = 0;
      resp_ready = 1'b1;
      repeat (5) step();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
